// File: rtl/lock_seq_pkg.sv
// Shared types and constants for the lock sequencer: FSM states, status encodings, digit width.
// Build option LOCK_SEQ_AUTORELOCK_EN is consumed by lock_sequencer, not by this package.
package lock_seq_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    StLocked,
    StEntry,
    StOpen,
    StProgram,
    StLockout
  } state_e;

  localparam logic [1:0] STAT_LOCKED  = 2'b00;
  localparam logic [1:0] STAT_OPEN    = 2'b01;
  localparam logic [1:0] STAT_PROG    = 2'b10;
  localparam logic [1:0] STAT_LOCKOUT = 2'b11;

  // ENTRY is still "locked" from the display's point of view.
  function automatic logic [1:0] status_of(state_e s);
    case (s)
      StOpen:    return STAT_OPEN;
      StProgram: return STAT_PROG;
      StLockout: return STAT_LOCKOUT;
      default:   return STAT_LOCKED;
    endcase
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_seq_if.sv
// Pulse/digit inputs and display-facing outputs of the lock sequencer.
// The sequencer uses the slave modport; whoever drives the pulses uses master.
interface lock_seq_if;
  import lock_seq_pkg::*;

  logic               pulse_enter;
  logic               pulse_change;
  logic [DIGIT_W-1:0] sw;
  logic [1:0]         status;
  logic [2:0]         digit_idx;
  logic               err;
  logic               unlocked;

  modport master (
    output pulse_enter,
    output pulse_change,
    output sw,
    input  status,
    input  digit_idx,
    input  err,
    input  unlocked
  );

  modport slave (
    input  pulse_enter,
    input  pulse_change,
    input  sw,
    output status,
    output digit_idx,
    output err,
    output unlocked
  );

endinterface

// File: rtl/lock_seq_timer.sv
// Loadable down-counter with zero flag, shared by the lockout and auto-relock timeouts.
// Load takes priority over counting; the count holds at zero.
module lock_seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Multi-digit code entry, failed-attempt lockout and code reprogramming for the digital lock.
// Define LOCK_SEQ_AUTORELOCK_EN to relock automatically after RELOCK_CYCLES idle cycles in OPEN.
module lock_sequencer
  import lock_seq_pkg::*;
#(
  parameter int unsigned              DIGITS         = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE    = 16'h1234,
  parameter int unsigned              MAX_FAIL       = 3,
  parameter int unsigned              LOCKOUT_CYCLES = 1000,
  parameter int unsigned              RELOCK_CYCLES  = 5000
) (
  input logic       clock,
  input logic       reset,
  lock_seq_if.slave bus
);

  localparam int unsigned CodeW = DIGITS * DIGIT_W;
  localparam int unsigned TMax  = max_u(LOCKOUT_CYCLES, RELOCK_CYCLES);
  localparam int unsigned TW    = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0] LockLoad = TW'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_SEQ_AUTORELOCK_EN
  localparam logic [TW-1:0] RelockLoad = TW'(RELOCK_CYCLES - 1);
`endif

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic               mism_q, mism_d;
  logic [3:0]         fail_q, fail_d;
  logic [CodeW-1:0]   code_q, code_d;
  logic [CodeW-1:0]   shadow_q, shadow_d;
  logic               err_q, err_d;
  logic [1:0]         status_q;
  logic               unlocked_q;

  logic [DIGIT_W-1:0] cur_digit;
  logic [CodeW-1:0]   shadow_wr;
  logic               last;
  logic               miss;
  logic [3:0]         fail_inc;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_en;
  logic               tmr_zero;

  lock_seq_timer #(
    .Width (TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Digit 0 lives in the most significant nibble.
  always_comb begin
    cur_digit = '0;
    shadow_wr = shadow_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (idx_q == 3'(d)) begin
        cur_digit = code_q[(DIGITS-1-d)*DIGIT_W +: DIGIT_W];
        shadow_wr[(DIGITS-1-d)*DIGIT_W +: DIGIT_W] = bus.sw;
      end
    end
  end

  assign last     = (idx_q == 3'(DIGITS - 1));
  assign miss     = (bus.sw != cur_digit);
  assign fail_inc = fail_q + 4'd1;

`ifdef LOCK_SEQ_AUTORELOCK_EN
  assign tmr_en = (state_q == StLockout) || (state_q == StOpen);
`else
  assign tmr_en = (state_q == StLockout);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mism_d   = mism_q;
    fail_d   = fail_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = LockLoad;

    unique case (state_q)
      StLocked, StEntry: begin
        if (bus.pulse_change) begin
          state_d = StLocked;
          idx_d   = '0;
          mism_d  = 1'b0;
        end else if (bus.pulse_enter) begin
          if (!last) begin
            state_d = StEntry;
            idx_d   = idx_q + 3'd1;
            mism_d  = mism_q | miss;
          end else begin
            idx_d  = '0;
            mism_d = 1'b0;
            if (!(mism_q | miss)) begin
              state_d = StOpen;
              fail_d  = '0;
`ifdef LOCK_SEQ_AUTORELOCK_EN
              tmr_load = 1'b1;
              tmr_val  = RelockLoad;
`endif
            end else begin
              fail_d = fail_inc;
              err_d  = 1'b1;
              if (fail_inc == 4'(MAX_FAIL)) begin
                state_d  = StLockout;
                tmr_load = 1'b1;
                tmr_val  = LockLoad;
              end else begin
                state_d = StLocked;
              end
            end
          end
        end
      end

      StOpen: begin
`ifdef LOCK_SEQ_AUTORELOCK_EN
        if (bus.pulse_enter || bus.pulse_change) begin
          tmr_load = 1'b1;
          tmr_val  = RelockLoad;
        end
`endif
        if (bus.pulse_change) begin
          state_d = StProgram;
          idx_d   = '0;
        end else if (bus.pulse_enter) begin
          state_d = StLocked;
          idx_d   = '0;
          mism_d  = 1'b0;
`ifdef LOCK_SEQ_AUTORELOCK_EN
        end else if (tmr_zero) begin
          state_d = StLocked;
          idx_d   = '0;
          mism_d  = 1'b0;
`endif
        end
      end

      StProgram: begin
        if (bus.pulse_change) begin
          state_d = StOpen;
          idx_d   = '0;
`ifdef LOCK_SEQ_AUTORELOCK_EN
          tmr_load = 1'b1;
          tmr_val  = RelockLoad;
`endif
        end else if (bus.pulse_enter) begin
          shadow_d = shadow_wr;
          if (last) begin
            // Commit includes the digit being written this cycle.
            code_d  = shadow_wr;
            state_d = StOpen;
            idx_d   = '0;
`ifdef LOCK_SEQ_AUTORELOCK_EN
            tmr_load = 1'b1;
            tmr_val  = RelockLoad;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      StLockout: begin
        if (tmr_zero) begin
          state_d = StLocked;
          fail_d  = '0;
          idx_d   = '0;
          mism_d  = 1'b0;
        end
      end

      default: begin
        state_d = StLocked;
        idx_d   = '0;
        mism_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StLocked;
      idx_q      <= '0;
      mism_q     <= 1'b0;
      fail_q     <= '0;
      code_q     <= RESET_CODE;
      shadow_q   <= '0;
      err_q      <= 1'b0;
      status_q   <= STAT_LOCKED;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mism_q     <= mism_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      status_q   <= status_of(state_d);
      unlocked_q <= (state_d == StOpen) || (state_d == StProgram);
    end
  end

  assign bus.status    = status_q;
  assign bus.digit_idx = idx_q;
  assign bus.err       = err_q;
  assign bus.unlocked  = unlocked_q;

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Multi-digit sequencing controller for the digital lock. It takes the single-cycle `enter`/`change` pulses from the input conditioners and the 4-bit switch value. It collects a code of `DIGITS` entries and checks them against an internally stored code. It also counts failed attempts into a timed lockout, supports reprogramming the code while open, and drives a 2-bit status to the existing 7-segment display decoder.

## Interface
Parameters:
- `DIGITS`, 4: number of 4-bit digits per code (1..8).
- `RESET_CODE`, 16'h1234: stored code after reset, `4*DIGITS` bits; digit 0 in the most significant nibble.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout (1..15).
- `LOCKOUT_CYCLES`, 1000: lockout duration in clock cycles (≥1).
- `RELOCK_CYCLES`, 5000: auto-relock timeout in cycles. Used only with the macro.

Ports:
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pulse_enter`, in, 1: one-cycle enter strobe.
- `pulse_change`, in, 1: one-cycle change strobe.
- `sw`, in, 4: current digit value.
- `status`, out, 2: 00 locked, 01 open, 10 program, 11 lockout. Reset 00.
- `digit_idx`, out, 3: index of the next digit expected. Reset 0.
- `err`, out, 1: one-cycle pulse on a failed attempt. Reset 0.
- `unlocked`, out, 1: high exactly in OPEN and PROGRAM. Reset 0.

## Operation
- States: LOCKED, ENTRY, OPEN, PROGRAM, LOCKOUT. Reset leaves the block in LOCKED with idx=0, fail=0, code=RESET_CODE, and all timers cleared.
- **LOCKED / ENTRY:**
  - `pulse_enter` compares `sw` with stored digit[idx] and ORs any inequality into a sticky mismatch flag.
  - On a non-final digit: idx+1 and the state is ENTRY.
  - On the final digit (idx==DIGITS-1), if the flag plus the current compare shows no mismatch: go to OPEN and clear fail.
  - On the final digit with a mismatch: fail+1 and `err` pulses. If the new fail equals MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1. Otherwise go to LOCKED.
  - idx and the mismatch flag clear on every return to LOCKED.
- **`pulse_change` in LOCKED/ENTRY:** aborts the partial entry. The state returns to LOCKED, idx=0, flag cleared, fail unchanged, no `err`.
- **OPEN:**
  - `pulse_enter` relocks: state LOCKED, idx=0.
  - `pulse_change` enters PROGRAM with idx=0.
- **PROGRAM:**
  - `pulse_enter` writes `sw` into shadow digit[idx] and increments idx.
  - On the final digit, the shadow is committed to the stored code in one cycle, including the final digit. The state returns to OPEN with idx=0.
  - `pulse_change` aborts: the shadow is discarded, the stored code is unchanged, and the state returns to OPEN.
- **LOCKOUT:**
  - All pulses are ignored and the timer decrements each cycle.
  - In the cycle the timer reads 0, the state goes to LOCKED and fail is cleared.
- **Simultaneous pulses:** when both pulses arrive in one cycle, `pulse_change` wins and `pulse_enter` is dropped.
- **Counter width:** fail saturates at MAX_FAIL, which cannot be exceeded because reaching it forces LOCKOUT.
- **Reset mid-operation:** reset in any state, including mid-PROGRAM or mid-LOCKOUT, restores the full reset condition. Any code written by PROGRAM is lost and the stored code reverts to RESET_CODE.

## Timing
- All outputs are registered. A pulse sampled at edge N produces updated `status`, `digit_idx`, `unlocked` and `err` after edge N.
- `err` is high for exactly one cycle, the cycle after the final failing digit.
- Lockout lasts exactly LOCKOUT_CYCLES cycles with `status`=11, counted from the first cycle `status`=11 is visible.
- Back-to-back pulses on consecutive cycles are each accepted. There is no required idle gap.

## Configuration
- `LOCK_SEQ_AUTORELOCK_EN` defined:
  - The timer loads RELOCK_CYCLES-1 on entry to OPEN and reloads on any pulse in OPEN.
  - When it reaches 0 in OPEN, the state goes to LOCKED with idx=0.
  - PROGRAM is not timed.
- `LOCK_SEQ_AUTORELOCK_EN` undefined: OPEN is held until `pulse_enter`, `pulse_change` or `reset`. RELOCK_CYCLES is ignored.

## Structure
- Package `lock_seq_pkg`:
  - State enum.
  - `status` encodings STAT_LOCKED, STAT_OPEN, STAT_PROG, STAT_LOCKOUT.
  - DIGIT_W=4.
- Sub-module `lock_seq_timer`: a loadable down-counter with a zero flag. It is sized to max(LOCKOUT_CYCLES, RELOCK_CYCLES) and shared by lockout and auto-relock, since the two are never active together.

## Test plan
All scenarios use DIGITS=4, RESET_CODE=16'h1234, MAX_FAIL=3, LOCKOUT_CYCLES=8, RELOCK_CYCLES=16.
- Enter 1,2,3,4 -> `status`=01 and `unlocked`=1 one cycle after the 4th pulse; `err` never high.
- Enter 1,2,3,5 three times -> `err` pulses after each attempt; after the 3rd, `status`=11 for exactly 8 cycles; pulses during that time are ignored; then `status`=00 and fail is cleared, and 1,2,3,4 opens.
- Starting from open: change, then 9,8,7,6 -> back to OPEN; then enter (relock), 1,2,3,4 fails and 9,8,7,6 opens. Repeat with a change after 2 digits -> the code stays 1234.
- Enter 1,2, then change; then 1,2,3,4 -> opens, with `digit_idx` back at 0 after the abort and no `err`.
- Both pulses in the same cycle during ENTRY -> treated as an abort. Reset asserted mid-PROGRAM -> all outputs at reset values and the code is 1234 again.
- With `LOCK_SEQ_AUTORELOCK_EN`: open, then idle 16 cycles -> `status`=00. A pulse at cycle 10 restarts the count. Without the macro, 100 idle cycles leave `status`=01.
